data_mem_responder: RTL and testbench

Word-organised data memory answering the CPU's load/store requests over a valid/ready request/response handshake. It sits on the CPU's LOAD/STORE path, opposite the core's memory stage. It executes RV32I byte, halfword and word accesses with sign/zero extension after a fixed, parameterised access latency. It holds one transaction outstanding at a time and flags misaligned, out-of-range or illegal accesses.

---
 rtl/data_mem_responder.sv | 241 ++++++++++++++++++++++++
 tb/tb_data_mem_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder
// Word-organised data memory serving RV32I loads and stores over a
// valid/ready request/response handshake. One transaction is in flight at a
// time. The access happens after a fixed, parameterised latency, and
// misaligned, out-of-range or illegal-width accesses are flagged with
// resp_error.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  req_funct3,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_error
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [31:0]   BYTE_LIMIT = 32'(4 * DEPTH_WORDS);
    localparam logic [CW-1:0] CNT_INIT   = CW'(LATENCY - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t        state_r;
    state_t        next_state_s;
    logic [CW-1:0] cnt_r;
    logic [CW-1:0] cnt_next_s;

    // Request fields captured at accept.
    logic          lat_write_r;
    logic [31:0]   lat_addr_r;
    logic [31:0]   lat_wdata_r;
    logic [2:0]    lat_funct3_r;

    // Fields feeding the access. With LATENCY=1 the access happens on the
    // accept edge itself, so it must use the live request fields.
    logic          eff_write_s;
    logic [31:0]   eff_addr_s;
    logic [31:0]   eff_wdata_s;
    logic [2:0]    eff_funct3_s;
    logic          do_access_s;

    logic          acc_error_s;
    logic [AW-1:0] word_idx_s;
    logic [31:0]   rd_word_s;
    logic [31:0]   load_data_s;
    logic [31:0]   store_data_s;

    logic          resp_valid_r;
    logic [31:0]   resp_rdata_r;
    logic          resp_error_r;

    logic [31:0]   mem_r [DEPTH_WORDS];

    // Flags out-of-range, misaligned and illegal width codes.
    function automatic logic access_error(input logic        write,
                                          input logic [31:0] addr,
                                          input logic [2:0]  f3);
        logic bad;
        case (f3)
            3'b000:  bad = 1'b0;
            3'b001:  bad = addr[0];
            3'b010:  bad = (addr[1:0] != 2'b00);
            3'b100:  bad = write;
            3'b101:  bad = write | addr[0];
            default: bad = 1'b1;
        endcase
        return bad | (addr >= BYTE_LIMIT);
    endfunction

    // Selects the addressed byte/halfword and extends it per funct3.
    function automatic logic [31:0] load_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [2:0]  f3);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            2'd3:    b = word[31:24];
            default: b = 8'd0;
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b010:  r = word;
            3'b100:  r = {24'd0, b};
            3'b101:  r = {16'd0, h};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    // Merges store data into the old word, leaving other bytes untouched.
    function automatic logic [31:0] store_merge(input logic [31:0] old,
                                                input logic [31:0] wdata,
                                                input logic [1:0]  lane,
                                                input logic [2:0]  f3);
        logic [31:0] r;
        r = old;
        case (f3)
            3'b000: begin
                case (lane)
                    2'd0:    r[7:0]   = wdata[7:0];
                    2'd1:    r[15:8]  = wdata[7:0];
                    2'd2:    r[23:16] = wdata[7:0];
                    2'd3:    r[31:24] = wdata[7:0];
                    default: r = old;
                endcase
            end
            3'b001: begin
                if (lane[1]) begin
                    r[31:16] = wdata[15:0];
                end else begin
                    r[15:0] = wdata[15:0];
                end
            end
            3'b010:  r = wdata;
            default: r = old;
        endcase
        return r;
    endfunction

    // Next-state, countdown and access-strobe logic.
    always_comb begin
        next_state_s = state_r;
        cnt_next_s   = cnt_r;
        do_access_s  = 1'b0;
        eff_write_s  = lat_write_r;
        eff_addr_s   = lat_addr_r;
        eff_wdata_s  = lat_wdata_r;
        eff_funct3_s = lat_funct3_r;
        case (state_r)
            ST_IDLE: begin
                eff_write_s  = req_write;
                eff_addr_s   = req_addr;
                eff_wdata_s  = req_wdata;
                eff_funct3_s = req_funct3;
                if (req_valid) begin
                    cnt_next_s = CNT_INIT;
                    if (LATENCY == 1) begin
                        next_state_s = ST_RESP;
                        do_access_s  = 1'b1;
                    end else begin
                        next_state_s = ST_WAIT;
                    end
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                cnt_next_s = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    next_state_s = ST_RESP;
                    do_access_s  = 1'b1;
                end else begin
                    next_state_s = ST_WAIT;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    next_state_s = ST_IDLE;
                end else begin
                    next_state_s = ST_RESP;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Address decode, read path and store merge for the pending access.
    always_comb begin
        acc_error_s  = access_error(eff_write_s, eff_addr_s, eff_funct3_s);
        word_idx_s   = eff_addr_s[AW+1:2];
        rd_word_s    = mem_r[word_idx_s];
        load_data_s  = load_extract(rd_word_s, eff_addr_s[1:0], eff_funct3_s);
        store_data_s = store_merge(rd_word_s, eff_wdata_s, eff_addr_s[1:0],
                                   eff_funct3_s);
    end

    // State, countdown, request latch and registered response.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            cnt_r        <= '0;
            lat_write_r  <= 1'b0;
            lat_addr_r   <= 32'd0;
            lat_wdata_r  <= 32'd0;
            lat_funct3_r <= 3'd0;
            resp_valid_r <= 1'b0;
            resp_rdata_r <= 32'd0;
            resp_error_r <= 1'b0;
        end else begin
            state_r      <= next_state_s;
            cnt_r        <= cnt_next_s;
            resp_valid_r <= (next_state_s == ST_RESP);
            if (state_r == ST_IDLE && req_valid) begin
                lat_write_r  <= req_write;
                lat_addr_r   <= req_addr;
                lat_wdata_r  <= req_wdata;
                lat_funct3_r <= req_funct3;
            end
            if (do_access_s) begin
                resp_error_r <= acc_error_s;
                if (acc_error_s || eff_write_s) begin
                    resp_rdata_r <= 32'd0;
                end else begin
                    resp_rdata_r <= load_data_s;
                end
            end
        end
    end

    // Store commit; the array itself is never cleared by reset.
    always_ff @(posedge clk) begin
        if (!reset && do_access_s && eff_write_s && !acc_error_s) begin
            mem_r[word_idx_s] <= store_data_s;
        end
    end

    assign req_ready  = (state_r == ST_IDLE) && !reset;
    assign resp_valid = resp_valid_r;
    assign resp_rdata = resp_rdata_r;
    assign resp_error = resp_error_r;

endmodule

// File: tb/tb_data_mem_responder.sv
// Scoreboard bench for data_mem_responder. Instance 0 runs with LATENCY=2
// and instance 1 with LATENCY=1. Stimulus pushes expected responses into a
// per-instance queue, and a negedge monitor pops and compares each response
// handshake.
module tb_data_mem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst  [2];
    logic        rv   [2];
    logic        rr   [2];
    logic        rw   [2];
    logic [31:0] ra   [2];
    logic [31:0] rwd  [2];
    logic [2:0]  rf   [2];
    logic        rsv  [2];
    logic        rsr  [2];
    logic [31:0] rsd  [2];
    logic        rse  [2];

    logic [32:0] exp_q0 [$];
    logic [32:0] exp_q1 [$];

    int n_checks = 0;
    int n_fail   = 0;

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) dut0 (
        .clk(clk), .reset(rst[0]), .req_valid(rv[0]), .req_ready(rr[0]),
        .req_write(rw[0]), .req_addr(ra[0]), .req_wdata(rwd[0]),
        .req_funct3(rf[0]), .resp_valid(rsv[0]), .resp_ready(rsr[0]),
        .resp_rdata(rsd[0]), .resp_error(rse[0]));

    data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) dut1 (
        .clk(clk), .reset(rst[1]), .req_valid(rv[1]), .req_ready(rr[1]),
        .req_write(rw[1]), .req_addr(ra[1]), .req_wdata(rwd[1]),
        .req_funct3(rf[1]), .resp_valid(rsv[1]), .resp_ready(rsr[1]),
        .resp_rdata(rsd[1]), .resp_error(rse[1]));

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: event did not occur", name);
    endtask

    task automatic push_exp(input int d, input logic [31:0] rd, input logic e);
        if (d == 0) exp_q0.push_back({e, rd});
        else        exp_q1.push_back({e, rd});
    endtask

    task automatic pop_check(input int d);
        logic [32:0] e;
        bit have;
        have = 1'b0;
        e    = 33'd0;
        if (d == 0) begin
            if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); have = 1'b1; end
        end else begin
            if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
        end
        if (!have) begin
            fail_now($sformatf("unexpected_resp_dut%0d", d));
        end else begin
            check($sformatf("rdata_dut%0d", d), rsd[d], e[31:0]);
            check($sformatf("error_dut%0d", d), {31'd0, rse[d]}, {31'd0, e[32]});
        end
    endtask

    // Monitor: a response handshake completes at the next rising edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rsv[d] && rsr[d] && !rst[d]) pop_check(d);
        end
    end

    // Waits (bounded) for req_ready with req_valid held; returns just after
    // the accept edge.
    task automatic wait_accept(input int d, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rr[d]) begin ok = 1'b1; break; end
        end
        if (ok) begin
            @(posedge clk); #1;
        end else begin
            fail_now($sformatf("accept_timeout_dut%0d", d));
        end
    endtask

    // Waits (bounded) for resp_valid; lat counts from 1 at the first negedge
    // after the accept edge.
    task automatic wait_resp(input int d, output int lat);
        lat = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (rsv[d]) begin lat = i; break; end
        end
        if (lat == 0) fail_now($sformatf("resp_timeout_dut%0d", d));
    endtask

    task automatic txn(input int d, input logic w, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [2:0] f3,
                       input logic [31:0] exp_rd, input logic exp_err);
        bit ok;
        int lat;
        push_exp(d, exp_rd, exp_err);
        @(posedge clk); #1;
        rv[d] = 1'b1; rw[d] = w; ra[d] = addr; rwd[d] = wdata; rf[d] = f3;
        wait_accept(d, ok);
        // Scramble request fields after accept; the DUT must use its latch.
        rv[d] = 1'b0; rw[d] = ~w; ra[d] = 32'h0000_0001;
        rwd[d] = 32'hA5A5_A5A5; rf[d] = 3'b111;
        if (ok) begin
            wait_resp(d, lat);
            if (lat != 0) check($sformatf("latency_dut%0d", d), 32'(lat), (d == 0) ? 32'd2 : 32'd1);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        int lat;
        for (int d = 0; d < 2; d++) begin
            rst[d] = 1'b1; rv[d] = 1'b0; rw[d] = 1'b0; ra[d] = 32'd0;
            rwd[d] = 32'd0; rf[d] = 3'd0; rsr[d] = 1'b1;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset_req_ready_dut%0d", d), {31'd0, rr[d]}, 32'd0);
            check($sformatf("reset_resp_valid_dut%0d", d), {31'd0, rsv[d]}, 32'd0);
            check($sformatf("reset_rdata_dut%0d", d), rsd[d], 32'd0);
            check($sformatf("reset_error_dut%0d", d), {31'd0, rse[d]}, 32'd0);
        end
        @(posedge clk); #1;
        rst[0] = 1'b0; rst[1] = 1'b0;
        @(negedge clk);
        check("post_reset_req_ready", {31'd0, rr[0]}, 32'd1);

        // Store/load, extension, partial stores, errors on LATENCY=2.
        txn(0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD_BEEF, 1'b0);
        txn(0, 1'b0, 32'h13, 32'h0, 3'b000, 32'hFFFF_FFDE, 1'b0);
        txn(0, 1'b0, 32'h13, 32'h0, 3'b100, 32'h0000_00DE, 1'b0);
        txn(0, 1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF_DEAD, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 3'b101, 32'h0000_BEEF, 1'b0);
        txn(0, 1'b1, 32'h11, 32'h0000_00AA, 3'b000, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'hDEAD_AAEF, 1'b0);
        txn(0, 1'b1, 32'h12, 32'h0000_1234, 3'b001, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'h1234_AAEF, 1'b0);
        txn(0, 1'b0, 32'h12, 32'h0, 3'b010, 32'h0, 1'b1);
        txn(0, 1'b1, 32'h11, 32'h0000_FFFF, 3'b001, 32'h0, 1'b1);
        txn(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'h1234_AAEF, 1'b0);
        txn(0, 1'b0, 32'h1000, 32'h0, 3'b010, 32'h0, 1'b1);
        txn(0, 1'b0, 32'hFFC, 32'h0, 3'b010, 32'h0, 1'b0);
        txn(0, 1'b0, 32'h10, 32'h0, 3'b011, 32'h0, 1'b1);
        txn(0, 1'b1, 32'h10, 32'hFFFF_FFFF, 3'b100, 32'h0, 1'b1);
        txn(0, 1'b0, 32'h10, 32'h0, 3'b010, 32'h1234_AAEF, 1'b0);

        // Backpressure: held response, concurrent request must wait.
        @(posedge clk); #1;
        rsr[0] = 1'b0;
        push_exp(0, 32'h1234_AAEF, 1'b0);
        rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 32'h10; rf[0] = 3'b010;
        wait_accept(0, ok);
        push_exp(0, 32'h0000_00AA, 1'b0);
        ra[0] = 32'h11; rf[0] = 3'b100;
        if (ok) begin
            wait_resp(0, lat);
            for (int i = 0; i < 5; i++) begin
                if (i != 0) @(negedge clk);
                check("bp_resp_valid", {31'd0, rsv[0]}, 32'd1);
                check("bp_rdata_stable", rsd[0], 32'h1234_AAEF);
                check("bp_req_ready", {31'd0, rr[0]}, 32'd0);
            end
            @(posedge clk); #1;
            rsr[0] = 1'b1;
            @(negedge clk);
            @(posedge clk); #1;
            @(negedge clk);
            check("bp_ready_after_hs", {31'd0, rr[0]}, 32'd1);
            check("bp_valid_after_hs", {31'd0, rsv[0]}, 32'd0);
            @(posedge clk); #1;
            rv[0] = 1'b0;
            @(negedge clk);
            check("bp_held_accepted", {31'd0, rr[0]}, 32'd0);
            wait_resp(0, lat);
            @(posedge clk); #1;
        end

        // Reset during WAIT drops the store.
        rv[0] = 1'b1; rw[0] = 1'b1; ra[0] = 32'h20; rwd[0] = 32'h55; rf[0] = 3'b010;
        wait_accept(0, ok);
        rv[0] = 1'b0;
        rst[0] = 1'b1;
        @(negedge clk);
        check("rst_wait_req_ready", {31'd0, rr[0]}, 32'd0);
        @(posedge clk); #1;
        rst[0] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rst_wait_no_resp", {31'd0, rsv[0]}, 32'd0);
        end
        check("rst_wait_ready_back", {31'd0, rr[0]}, 32'd1);
        txn(0, 1'b0, 32'h20, 32'h0, 3'b010, 32'h0, 1'b0);

        // LATENCY=1 instance.
        txn(1, 1'b1, 32'h10, 32'hCAFE_F00D, 3'b010, 32'h0, 1'b0);
        txn(1, 1'b0, 32'h10, 32'h0, 3'b010, 32'hCAFE_F00D, 1'b0);
        txn(1, 1'b0, 32'h12, 32'h0, 3'b001, 32'hFFFF_CAFE, 1'b0);
        // Reset while a store sits in RESP: store remains, no response.
        @(posedge clk); #1;
        rsr[1] = 1'b0;
        rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 32'h24; rwd[1] = 32'h77; rf[1] = 3'b010;
        wait_accept(1, ok);
        rv[1] = 1'b0;
        @(negedge clk);
        check("l1_resp_in_resp", {31'd0, rsv[1]}, 32'd1);
        @(posedge clk); #1;
        rst[1] = 1'b1;
        @(negedge clk);
        check("l1_rst_req_ready", {31'd0, rr[1]}, 32'd0);
        @(posedge clk); #1;
        rst[1] = 1'b0;
        rsr[1] = 1'b1;
        @(negedge clk);
        check("l1_rst_no_resp", {31'd0, rsv[1]}, 32'd0);
        check("l1_rst_ready_back", {31'd0, rr[1]}, 32'd1);
        txn(1, 1'b0, 32'h24, 32'h0, 3'b010, 32'h0000_0077, 1'b0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("queue0_drained", 32'(exp_q0.size()), 32'd0);
        check("queue1_drained", 32'(exp_q1.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
